pipeline_hazard_unit: RTL and testbench

Parametrised hazard and forwarding unit for the in-order RISC-V pipeline. It tracks every in-flight destination register from execute to writeback in a shift register. From that it drives per-operand forwarding selects for the decode stage, load-use stalls sized by a configurable load latency, and branch flush/bubble controls. It also keeps saturating stall and flush event counters. It sits beside the decode-stage controller and takes the decoded register fields and write/load flags as inputs.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/pipeline_hazard_unit_fwd_select.sv | 36 +++
 rtl/pipeline_hazard_unit.sv | 118 +++++++++++
 tb/tb_pipeline_hazard_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding unit.
package hazard_pkg;

   localparam int CNT_W   = 32;
   localparam int FWD_RF  = 0;
   // Widest register address a slot can hold; narrower designs zero-extend.
   localparam int SLOT_AW = 8;

   typedef struct packed {
      logic               valid;
      logic [SLOT_AW-1:0] rd;
      logic               reg_wr;
      logic               is_load;
   } slot_t;

   function automatic bit params_ok(input int num_stages, input int load_latency,
                                    input int reg_aw);
      return (num_stages >= 2) && (num_stages <= 7) &&
             (load_latency >= 1) && (load_latency <= num_stages - 1) &&
             (reg_aw >= 1) && (reg_aw <= SLOT_AW);
   endfunction

endpackage

// File: rtl/pipeline_hazard_unit_fwd_select.sv
// Priority matcher: finds the youngest in-flight slot writing a given source register.
module fwd_select
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int REG_AW     = 5,
   parameter int FWD_W      = 2
) (
   input  slot_t             slots_i [1:NUM_STAGES],
   input  logic [REG_AW-1:0] src_i,
   input  logic              src_used_i,
   output logic              hit_o,
   output logic [FWD_W-1:0]  idx_o,
   output logic              is_load_hit_o
);

   logic [SLOT_AW-1:0] src_ext;

   assign src_ext = SLOT_AW'(src_i);

   // Scan oldest to youngest so the lowest-numbered match is the one left standing.
   always_comb begin
      hit_o         = 1'b0;
      idx_o         = FWD_W'(FWD_RF);
      is_load_hit_o = 1'b0;
      for (int k = NUM_STAGES; k >= 1; k--) begin
         if (slots_i[k].valid && slots_i[k].reg_wr && src_used_i &&
             (slots_i[k].rd == src_ext) && (slots_i[k].rd != '0)) begin
            hit_o         = 1'b1;
            idx_o         = FWD_W'(k);
            is_load_hit_o = slots_i[k].is_load;
         end
      end
   end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding unit: tracks in-flight destinations, drives forwarding
// selects, load-use stalls, branch flush/bubble and saturating event counters.
module pipeline_hazard_unit
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES   = 3,
   parameter int LOAD_LATENCY = 1,
   parameter int REG_AW       = 5,
   parameter int FWD_W        = $clog2(NUM_STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_wr,
   input  logic              id_is_load,
   input  logic              ex_br_taken,
   output logic [FWD_W-1:0]  fwd_a,
   output logic [FWD_W-1:0]  fwd_b,
   output logic              stall,
   output logic              bubble,
   output logic              flush,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   if (!params_ok(NUM_STAGES, LOAD_LATENCY, REG_AW)) begin : g_bad_params
      $error("pipeline_hazard_unit: illegal NUM_STAGES/LOAD_LATENCY/REG_AW combination");
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      sat_inc = (&c) ? c : c + 1'b1;
   endfunction

   slot_t            slot_q [1:NUM_STAGES];
   slot_t            slot_d [1:NUM_STAGES];
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic             hit_a, hit_b, ld_a, ld_b;
   logic [FWD_W-1:0] idx_a, idx_b;
   logic             lu_a, lu_b;

   fwd_select #(.NUM_STAGES(NUM_STAGES), .REG_AW(REG_AW), .FWD_W(FWD_W)) u_fwd_a (
      .slots_i       (slot_q),
      .src_i         (id_rs1),
      .src_used_i    (id_rs1_used),
      .hit_o         (hit_a),
      .idx_o         (idx_a),
      .is_load_hit_o (ld_a)
   );

   fwd_select #(.NUM_STAGES(NUM_STAGES), .REG_AW(REG_AW), .FWD_W(FWD_W)) u_fwd_b (
      .slots_i       (slot_q),
      .src_i         (id_rs2),
      .src_used_i    (id_rs2_used),
      .hit_o         (hit_b),
      .idx_o         (idx_b),
      .is_load_hit_o (ld_b)
   );

   // A load is not forwardable until it has moved past slot LOAD_LATENCY.
   assign lu_a = id_valid && hit_a && ld_a && (idx_a <= FWD_W'(LOAD_LATENCY));
   assign lu_b = id_valid && hit_b && ld_b && (idx_b <= FWD_W'(LOAD_LATENCY));

   // The decode instruction is wrong-path on a taken branch, so flush overrides stall.
   always_comb begin
      flush  = ex_br_taken;
      stall  = (lu_a || lu_b) && !ex_br_taken;
      bubble = stall || flush;
      fwd_a  = FWD_W'(FWD_RF);
      fwd_b  = FWD_W'(FWD_RF);
      if (id_valid && !stall) begin
         fwd_a = idx_a;
         fwd_b = idx_b;
      end
   end

   always_comb begin
      slot_d[1] = '0;
      if (id_valid && !stall && !flush) begin
         slot_d[1].valid   = 1'b1;
         slot_d[1].rd      = SLOT_AW'(id_rd);
         slot_d[1].reg_wr  = id_reg_wr;
         slot_d[1].is_load = id_is_load;
      end
      for (int k = 2; k <= NUM_STAGES; k++) begin
         slot_d[k] = slot_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k <= NUM_STAGES; k++) begin
            slot_q[k].valid <= 1'b0;
         end
      end else begin
         slot_q <= slot_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
         if (flush) flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed instruction streams with a scoreboard of expected outputs.
module tb_pipeline_hazard_unit;

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
      logic       br;
   } instr_t;

   typedef struct {
      string      tag;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       st;
      logic       bu;
      logic       fl;
      bit         cf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid    [2];
   logic [4:0]  id_rs1      [2];
   logic [4:0]  id_rs2      [2];
   logic        id_rs1_used [2];
   logic        id_rs2_used [2];
   logic [4:0]  id_rd       [2];
   logic        id_reg_wr   [2];
   logic        id_is_load  [2];
   logic        ex_br_taken [2];
   logic [1:0]  fwd_a       [2];
   logic [1:0]  fwd_b       [2];
   logic        stall       [2];
   logic        bubble      [2];
   logic        flush       [2];
   logic [31:0] stall_count [2];
   logic [31:0] flush_count [2];

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   pipeline_hazard_unit #(.NUM_STAGES(3), .LOAD_LATENCY(1), .REG_AW(5)) u_dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid[0]), .id_rs1(id_rs1[0]), .id_rs2(id_rs2[0]),
      .id_rs1_used(id_rs1_used[0]), .id_rs2_used(id_rs2_used[0]), .id_rd(id_rd[0]),
      .id_reg_wr(id_reg_wr[0]), .id_is_load(id_is_load[0]), .ex_br_taken(ex_br_taken[0]),
      .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .stall(stall[0]), .bubble(bubble[0]),
      .flush(flush[0]), .stall_count(stall_count[0]), .flush_count(flush_count[0])
   );

   pipeline_hazard_unit #(.NUM_STAGES(3), .LOAD_LATENCY(2), .REG_AW(5)) u_dut2 (
      .clk(clk), .rst(rst), .id_valid(id_valid[1]), .id_rs1(id_rs1[1]), .id_rs2(id_rs2[1]),
      .id_rs1_used(id_rs1_used[1]), .id_rs2_used(id_rs2_used[1]), .id_rd(id_rd[1]),
      .id_reg_wr(id_reg_wr[1]), .id_is_load(id_is_load[1]), .ex_br_taken(ex_br_taken[1]),
      .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .stall(stall[1]), .bubble(bubble[1]),
      .flush(flush[1]), .stall_count(stall_count[1]), .flush_count(flush_count[1])
   );

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic instr_t mk(input logic v, input int rs1, input logic u1, input int rs2,
                                 input logic u2, input int rd, input logic wr, input logic ld,
                                 input logic br);
      instr_t i;
      i.v = v; i.rs1 = 5'(rs1); i.u1 = u1; i.rs2 = 5'(rs2); i.u2 = u2;
      i.rd = 5'(rd); i.wr = wr; i.ld = ld; i.br = br;
      return i;
   endfunction

   function automatic exp_t ex(input string tag, input int fa, input int fb, input logic st,
                               input logic bu, input logic fl, input bit cf);
      exp_t e;
      e.tag = tag; e.fa = 2'(fa); e.fb = 2'(fb); e.st = st; e.bu = bu; e.fl = fl; e.cf = cf;
      return e;
   endfunction

   task automatic idle_all();
      for (int i = 0; i < 2; i++) begin
         id_valid[i] = 1'b0; id_rs1[i] = '0; id_rs2[i] = '0; id_rs1_used[i] = 1'b0;
         id_rs2_used[i] = 1'b0; id_rd[i] = '0; id_reg_wr[i] = 1'b0; id_is_load[i] = 1'b0;
         ex_br_taken[i] = 1'b0;
      end
   endtask

   // One decode cycle on DUT s: drive after the edge, compare at the falling edge.
   task automatic step(input int s, input bit r, input instr_t in, input exp_t e);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r;
      idle_all();
      id_valid[s] = in.v; id_rs1[s] = in.rs1; id_rs1_used[s] = in.u1; id_rs2[s] = in.rs2;
      id_rs2_used[s] = in.u2; id_rd[s] = in.rd; id_reg_wr[s] = in.wr; id_is_load[s] = in.ld;
      ex_br_taken[s] = in.br;
      sb_q.push_back(e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         chk_eq("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         x = sb_q.pop_front();
         if (x.cf) begin
            chk_eq({x.tag, ".fwd_a"}, 32'(fwd_a[s]), 32'(x.fa));
            chk_eq({x.tag, ".fwd_b"}, 32'(fwd_b[s]), 32'(x.fb));
         end
         chk_eq({x.tag, ".stall"},  32'(stall[s]),  32'(x.st));
         chk_eq({x.tag, ".bubble"}, 32'(bubble[s]), 32'(x.bu));
         chk_eq({x.tag, ".flush"},  32'(flush[s]),  32'(x.fl));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_all();
      rst = 1'b1;

      // Reset: slots empty, flush follows the branch input, counters clear
      step(0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), ex("rst_br", 0, 0, 0, 1, 1, 1));
      chk_eq("rst.stall_cnt", stall_count[0], 32'd0);
      chk_eq("rst.flush_cnt", flush_count[0], 32'd0);
      step(0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), ex("rst_idle", 0, 0, 0, 0, 0, 1));
      chk_eq("rst2.flush_cnt", flush_count[0], 32'd0);

      // Basic forwarding from slots 1, 2 and 3
      step(0, 0, mk(1, 1, 1, 2, 1, 5, 1, 0, 0),   ex("fwd_none", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 5, 1, 3, 1, 9, 1, 0, 0),   ex("fwd_s1", 1, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 1, 1, 2, 1, 10, 1, 0, 0),  ex("indep", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 5, 1, 9, 1, 11, 1, 0, 0),  ex("fwd_s3_s2", 3, 2, 0, 0, 0, 1));
      step(0, 0, mk(0, 11, 1, 11, 1, 0, 0, 0, 0), ex("idle_nofwd", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 11, 1, 10, 1, 12, 1, 0, 0), ex("fwd_s2_s3", 2, 3, 0, 0, 0, 1));

      // Load-use with LOAD_LATENCY=1
      step(0, 0, mk(1, 2, 1, 0, 0, 6, 1, 1, 0),   ex("lw6", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 6, 1, 6, 1, 7, 1, 0, 0),   ex("lu_stall", 0, 0, 1, 1, 0, 1));
      step(0, 0, mk(1, 6, 1, 6, 1, 7, 1, 0, 0),   ex("lu_fwd", 2, 2, 0, 0, 0, 1));
      chk_eq("lu.stall_cnt", stall_count[0], 32'd1);

      // Youngest writer wins; x0 never forwards or stalls
      step(0, 0, mk(1, 0, 1, 0, 0, 8, 1, 0, 0),   ex("x8a", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 1, 1, 1, 1, 13, 1, 0, 0),  ex("x13", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 0, 1, 0, 0, 8, 1, 0, 0),   ex("x8b", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 8, 1, 8, 1, 14, 1, 0, 0),  ex("youngest", 1, 1, 0, 0, 0, 1));
      step(0, 0, mk(1, 1, 1, 2, 1, 0, 1, 0, 0),   ex("wr_x0", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 0, 1, 0, 1, 0, 1, 1, 0),   ex("ld_x0", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 0, 1, 0, 1, 0, 1, 0, 0),   ex("x0_after_ld", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 0, 1, 0, 1, 15, 1, 0, 0),  ex("x0_all", 0, 0, 0, 0, 0, 1));

      // Operand-used qualification on each source
      step(0, 0, mk(1, 1, 1, 0, 0, 20, 1, 1, 0),  ex("lw20", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 20, 0, 20, 0, 21, 1, 0, 0), ex("unused", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 1, 1, 0, 0, 22, 1, 1, 0),  ex("lw22", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 22, 0, 22, 1, 26, 1, 0, 0), ex("lu_rs2", 0, 0, 1, 1, 0, 1));
      step(0, 0, mk(1, 22, 0, 22, 1, 26, 1, 0, 0), ex("rs2_fwd", 0, 2, 0, 0, 0, 1));
      chk_eq("rs2.stall_cnt", stall_count[0], 32'd2);

      // Branch flush beats a simultaneous load-use hazard
      step(0, 0, mk(1, 1, 1, 0, 0, 23, 1, 1, 0),  ex("lw23", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 23, 1, 0, 0, 24, 1, 0, 1), ex("br_flush", 0, 0, 0, 1, 1, 0));
      step(0, 0, mk(1, 23, 1, 24, 1, 27, 1, 0, 0), ex("post_flush", 2, 0, 0, 0, 0, 1));
      chk_eq("br.flush_cnt", flush_count[0], 32'd1);
      chk_eq("br.stall_cnt", stall_count[0], 32'd2);

      // Reset asserted while stalled
      step(0, 0, mk(1, 1, 1, 0, 0, 25, 1, 1, 0),  ex("lw25", 0, 0, 0, 0, 0, 1));
      step(0, 1, mk(1, 25, 1, 0, 0, 28, 1, 0, 0), ex("rst_stall", 0, 0, 1, 1, 0, 1));
      step(0, 0, mk(1, 25, 1, 0, 0, 28, 1, 0, 0), ex("post_rst", 0, 0, 0, 0, 0, 1));
      chk_eq("post_rst.stall_cnt", stall_count[0], 32'd0);
      chk_eq("post_rst.flush_cnt", flush_count[0], 32'd0);

      // Saturation: preload the stall counter just below its ceiling
      u_dut1.stall_cnt_q = 32'hFFFF_FFFE;
      step(0, 0, mk(1, 2, 1, 0, 0, 6, 1, 1, 0),   ex("sat_lw_a", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 6, 1, 6, 1, 7, 1, 0, 0),   ex("sat_stall_a", 0, 0, 1, 1, 0, 1));
      step(0, 0, mk(1, 6, 1, 6, 1, 7, 1, 0, 0),   ex("sat_fwd_a", 2, 2, 0, 0, 0, 1));
      chk_eq("sat.top", stall_count[0], 32'hFFFF_FFFF);
      step(0, 0, mk(1, 2, 1, 0, 0, 6, 1, 1, 0),   ex("sat_lw_b", 0, 0, 0, 0, 0, 1));
      step(0, 0, mk(1, 6, 1, 6, 1, 7, 1, 0, 0),   ex("sat_stall_b", 0, 0, 1, 1, 0, 1));
      step(0, 0, mk(1, 6, 1, 6, 1, 7, 1, 0, 0),   ex("sat_fwd_b", 2, 2, 0, 0, 0, 1));
      chk_eq("sat.hold", stall_count[0], 32'hFFFF_FFFF);

      // LOAD_LATENCY=2: two stall cycles, then forward from slot 3
      step(1, 0, mk(1, 2, 1, 0, 0, 6, 1, 1, 0),   ex("ll2_lw", 0, 0, 0, 0, 0, 1));
      step(1, 0, mk(1, 6, 1, 6, 1, 7, 1, 0, 0),   ex("ll2_stall1", 0, 0, 1, 1, 0, 1));
      step(1, 0, mk(1, 6, 1, 6, 1, 7, 1, 0, 0),   ex("ll2_stall2", 0, 0, 1, 1, 0, 1));
      step(1, 0, mk(1, 6, 1, 6, 1, 7, 1, 0, 0),   ex("ll2_fwd", 3, 3, 0, 0, 0, 1));
      chk_eq("ll2.stall_cnt", stall_count[1], 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
